// File: rtl/mesh_term_port.sv
// Terminal port on one edge of the mesh: formats client writes into packets
// queued toward the router, and pops and checks packets the router delivers.
module mesh_term_port #(
    parameter int         rows     = 4,
    parameter int         columns  = 4,
    parameter int         pckg_sz  = 40,
    parameter int         f_depth  = 4,
    parameter logic [3:0] my_row   = 4'd0,
    parameter logic [3:0] my_col   = 4'd1
) (
    input  logic                 clk,
    input  logic                 reset,

    input  logic                 wr_en,
    input  logic [3:0]           wr_row,
    input  logic [3:0]           wr_col,
    input  logic                 wr_mode,
    input  logic [pckg_sz-18:0]  wr_payload,
    output logic                 full,

    output logic [pckg_sz-1:0]   data_out_i_in,
    output logic                 pndng_i_in,
    input  logic                 popin,

    input  logic [pckg_sz-1:0]   data_out,
    input  logic                 pndng,
    output logic                 pop,

    input  logic                 rx_en,
    output logic                 rx_valid,
    output logic [pckg_sz-1:0]   rx_data,
    output logic [15:0]          rx_count,
    output logic [15:0]          rx_err_count,
    output logic [7:0]           drop_count,
    output logic                 underflow_err
);

    localparam int PW = (f_depth > 1) ? $clog2(f_depth) : 1;
    localparam int CW = $clog2(f_depth + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_POP  = 2'd1,
        S_WAIT = 2'd2
    } sink_state_t;

    // A bad parameter set stops elaboration instead of building a broken port.
    generate
        if (pckg_sz < 18 || f_depth < 2 ||
            int'(my_row) >= rows || int'(my_col) >= columns) begin : g_bad_cfg
            $error("mesh_term_port: invalid parameter set");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Source FIFO
    // ------------------------------------------------------------------
    logic [pckg_sz-1:0] fifo_mem [f_depth];
    logic [PW-1:0]      rd_ptr;
    logic [PW-1:0]      wr_ptr;
    logic [CW-1:0]      count;
    logic               push;
    logic               retire;
    logic [pckg_sz-1:0] wr_pkt;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(f_depth - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full          = (count == CW'(f_depth));
    assign pndng_i_in    = (count != '0);
    assign data_out_i_in = pndng_i_in ? fifo_mem[rd_ptr] : '0;

    // A full FIFO rejects the write even when the router pops in that cycle.
    assign push   = wr_en && !full;
    assign retire = popin && pndng_i_in;
    assign wr_pkt = {8'h00, wr_row, wr_col, wr_mode, wr_payload};

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            count         <= '0;
            drop_count    <= '0;
            underflow_err <= 1'b0;
        end else begin
            if (push)   wr_ptr <= ptr_inc(wr_ptr);
            if (retire) rd_ptr <= ptr_inc(rd_ptr);

            case ({push, retire})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase

            if (wr_en && full && drop_count != 8'hFF)
                drop_count <= drop_count + 8'd1;

            if (popin && !pndng_i_in)
                underflow_err <= 1'b1;
        end
    end

    // NOTE: the storage array has no reset; count gates every read, so stale
    // entries are never visible and the array can map onto plain RAM.
    always_ff @(posedge clk) begin
        if (reset && push)
            fifo_mem[wr_ptr] <= wr_pkt;
    end

    // ------------------------------------------------------------------
    // Sink FSM
    // ------------------------------------------------------------------
    sink_state_t state;
    sink_state_t state_nxt;
    logic        capture;
    logic        dest_ok;

    assign capture = (state == S_IDLE) && rx_en && pndng;
    assign dest_ok = (rx_data[pckg_sz-9 -: 4] == my_row) &&
                     (rx_data[pckg_sz-13 -: 4] == my_col);

    always_ff @(posedge clk) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // NOTE: every combinational output gets a default first, so no path
    // through the case leaves it unassigned and infers a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (capture) state_nxt = S_POP;
            S_POP:   state_nxt = S_WAIT;
            S_WAIT:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // pop is high for exactly the POP cycle; the router retires on that edge
    // and refreshes pndng/data_out during WAIT.
    always_comb begin
        pop      = 1'b0;
        rx_valid = 1'b0;
        if (state == S_POP) begin
            pop      = 1'b1;
            rx_valid = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_data      <= '0;
            rx_count     <= '0;
            rx_err_count <= '0;
        end else begin
            if (capture)
                rx_data <= data_out;
            if (state == S_POP) begin
                if (dest_ok) begin
                    if (rx_count != 16'hFFFF) rx_count <= rx_count + 16'd1;
                end else begin
                    if (rx_err_count != 16'hFFFF) rx_err_count <= rx_err_count + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mesh_term_port.sv
// Directed bench for mesh_term_port: source FIFO ordering, full/drop and
// underflow corners, sink pop cadence, destination checking and reset.
module tb_mesh_term_port;

    localparam int PS = 40;

    logic          clk;
    logic          reset;
    logic          wr_en;
    logic [3:0]    wr_row;
    logic [3:0]    wr_col;
    logic          wr_mode;
    logic [PS-18:0] wr_payload;
    logic          full;
    logic [PS-1:0] data_out_i_in;
    logic          pndng_i_in;
    logic          popin;
    logic [PS-1:0] data_out;
    logic          pndng;
    logic          pop;
    logic          rx_en;
    logic          rx_valid;
    logic [PS-1:0] rx_data;
    logic [15:0]   rx_count;
    logic [15:0]   rx_err_count;
    logic [7:0]    drop_count;
    logic          underflow_err;

    int total = 0;
    int bad   = 0;

    mesh_term_port #(
        .rows(4), .columns(4), .pckg_sz(PS), .f_depth(4),
        .my_row(4'd0), .my_col(4'd1)
    ) dut (
        .clk(clk), .reset(reset),
        .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col), .wr_mode(wr_mode),
        .wr_payload(wr_payload), .full(full),
        .data_out_i_in(data_out_i_in), .pndng_i_in(pndng_i_in), .popin(popin),
        .data_out(data_out), .pndng(pndng), .pop(pop),
        .rx_en(rx_en), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_count(rx_count), .rx_err_count(rx_err_count),
        .drop_count(drop_count), .underflow_err(underflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [PS-1:0] mk_pkt(input logic [3:0] r, input logic [3:0] c,
                                              input logic m, input logic [PS-18:0] p);
        return {8'h00, r, c, m, p};
    endfunction

    task automatic set_wr(input logic [3:0] r, input logic [3:0] c,
                          input logic m, input logic [PS-18:0] p);
        wr_en      = 1'b1;
        wr_row     = r;
        wr_col     = c;
        wr_mode    = m;
        wr_payload = p;
    endtask

    logic [PS-1:0] p  [5];
    logic [PS-1:0] q  [6];
    logic [PS-1:0] good_pkt;
    logic [PS-1:0] bad_pkt;

    initial begin
        reset = 1'b0; wr_en = 1'b0; wr_row = '0; wr_col = '0; wr_mode = 1'b0;
        wr_payload = '0; popin = 1'b0; data_out = '0; pndng = 1'b0; rx_en = 1'b0;

        // ---- 1: writes during reset have no effect; first write latency ----
        set_wr(4'd2, 4'd3, 1'b0, 23'h5A5A5A);
        repeat (5) tick();
        check("rst_pndng_i_in", pndng_i_in, 0);
        check("rst_full", full, 0);
        check("rst_data_out_i_in", data_out_i_in, 0);
        check("rst_pop", pop, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rx_data", rx_data, 0);
        check("rst_counters", {rx_count, rx_err_count, drop_count}, 0);
        check("rst_underflow", underflow_err, 0);
        wr_en = 1'b0;
        reset = 1'b1;
        tick();
        check("idle_pndng_i_in", pndng_i_in, 0);
        set_wr(4'd2, 4'd3, 1'b0, 23'h5A5A5A);
        tick();
        wr_en = 1'b0;
        check("t1_pndng_i_in", pndng_i_in, 1);
        check("t1_packet", data_out_i_in, 40'h0023_5A5A5A);
        popin = 1'b1;
        tick();
        popin = 1'b0;
        check("t1_drained", pndng_i_in, 0);
        check("t1_empty_data", data_out_i_in, 0);

        // ---- 2: fill to full, drop the fifth, drain in order ----
        for (int i = 0; i < 5; i++) p[i] = mk_pkt(4'(i), 4'(i + 1), 1'(i), 23'(32'h100 + i));
        for (int i = 0; i < 5; i++) begin
            set_wr(p[i][31:28], p[i][27:24], p[i][23], p[i][22:0]);
            tick();
            check($sformatf("t2_full_%0d", i), full, (i >= 3) ? 1 : 0);
        end
        wr_en = 1'b0;
        check("t2_drop_count", drop_count, 1);
        popin = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t2_order_%0d", i), data_out_i_in, p[i]);
            tick();
        end
        popin = 1'b0;
        check("t2_empty", pndng_i_in, 0);
        check("t2_no_underflow", underflow_err, 0);

        // ---- 3: simultaneous push/pop at count 2 and at full ----
        for (int i = 0; i < 6; i++) q[i] = mk_pkt(4'(i + 4), 4'(9 - i), 1'b1, 23'(32'h3000 + i));
        set_wr(q[0][31:28], q[0][27:24], q[0][23], q[0][22:0]); tick();
        set_wr(q[1][31:28], q[1][27:24], q[1][23], q[1][22:0]); tick();
        set_wr(q[2][31:28], q[2][27:24], q[2][23], q[2][22:0]); popin = 1'b1; tick();
        popin = 1'b0;
        check("t3_head_adv", data_out_i_in, q[1]);
        set_wr(q[3][31:28], q[3][27:24], q[3][23], q[3][22:0]); tick();
        check("t3_not_full_at3", full, 0);
        set_wr(q[4][31:28], q[4][27:24], q[4][23], q[4][22:0]); tick();
        wr_en = 1'b0;
        check("t3_full_at4", full, 1);
        check("t3_drop_unchanged", drop_count, 1);
        set_wr(q[5][31:28], q[5][27:24], q[5][23], q[5][22:0]); popin = 1'b1; tick();
        wr_en = 1'b0;
        check("t3_full_pushpop_full", full, 0);
        check("t3_full_pushpop_drop", drop_count, 2);
        for (int i = 2; i < 5; i++) begin
            check($sformatf("t3_order_%0d", i), data_out_i_in, q[i]);
            tick();
        end
        popin = 1'b0;
        check("t3_empty", pndng_i_in, 0);

        // ---- 4: popin on empty FIFO sets sticky underflow ----
        popin = 1'b1; tick(); popin = 1'b0;
        check("t4_underflow_set", underflow_err, 1);
        check("t4_still_empty", pndng_i_in, 0);
        set_wr(4'd1, 4'd1, 1'b0, 23'h7); tick(); wr_en = 1'b0;
        popin = 1'b1; tick(); popin = 1'b0;
        check("t4_underflow_sticky", underflow_err, 1);

        // ---- 5: sink cadence and destination checking ----
        good_pkt = mk_pkt(4'd0, 4'd1, 1'b0, 23'h1234);
        bad_pkt  = mk_pkt(4'd1, 4'd1, 1'b1, 23'h7777);
        data_out = good_pkt; pndng = 1'b1; rx_en = 1'b1;
        check("t5_pop_idle", pop, 0);
        for (int k = 0; k < 2; k++) begin
            tick();
            check($sformatf("t5_pop_hi_%0d", k), pop, 1);
            check($sformatf("t5_valid_hi_%0d", k), rx_valid, 1);
            check($sformatf("t5_rx_data_%0d", k), rx_data, good_pkt);
            tick();
            check($sformatf("t5_pop_lo1_%0d", k), pop, 0);
            check($sformatf("t5_valid_lo_%0d", k), rx_valid, 0);
            check($sformatf("t5_rx_count_%0d", k), rx_count, 16'(k + 1));
            tick();
            check($sformatf("t5_pop_lo2_%0d", k), pop, 0);
        end
        data_out = bad_pkt;
        tick();
        check("t5_bad_pop", pop, 1);
        check("t5_bad_rx_data", rx_data, bad_pkt);
        tick();
        check("t5_err_count", rx_err_count, 1);
        check("t5_count_hold", rx_count, 2);
        tick();

        // ---- 6: rx_en drop mid-transfer; reset during WAIT ----
        data_out = good_pkt;
        tick();
        check("t6_pop", pop, 1);
        rx_en = 1'b0;
        tick();
        check("t6_counted", rx_count, 3);
        tick();
        tick();
        check("t6_no_pop_a", pop, 0);
        tick();
        check("t6_no_pop_b", pop, 0);
        check("t6_count_hold", rx_count, 3);

        rx_en = 1'b1;
        set_wr(4'd3, 4'd3, 1'b0, 23'h55);
        tick();
        wr_en = 1'b0;
        check("t6_pop2", pop, 1);
        check("t6_src_pending", pndng_i_in, 1);
        tick();
        check("t6_count4", rx_count, 4);
        reset = 1'b0; rx_en = 1'b0;
        tick();
        check("t6_rst_rx_count", rx_count, 0);
        check("t6_rst_rx_err", rx_err_count, 0);
        check("t6_rst_pop", pop, 0);
        check("t6_rst_rx_data", rx_data, 0);
        check("t6_rst_fifo", pndng_i_in, 0);
        check("t6_rst_underflow", underflow_err, 0);
        check("t6_rst_drop", drop_count, 0);
        reset = 1'b1; rx_en = 1'b1;
        tick();
        check("t6_idle_after_rst", pop, 1);
        rx_en = 1'b0; pndng = 1'b0;
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
